// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divide scheduler.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_W = 8;
  localparam int NUM_REQ = 2;
  localparam logic [31:0] DZ_QUO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_quo_sh;
  logic [WIDTH:0]   w_div_ext;

  assign w_rem_sh  = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
  assign w_quo_sh  = {i_quo[WIDTH-2:0], 1'b0};
  assign w_div_ext = {1'b0, i_div};

  always_comb begin
    o_rem = w_rem_sh;
    o_quo = w_quo_sh;
    if (w_rem_sh >= w_div_ext) begin
      o_rem    = w_rem_sh - w_div_ext;
      o_quo[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sched.sv
// Round-robin shared divider: two requesters, one restoring step per clock,
// quotient/remainder returned on a valid/ready channel tagged with the id.
module div_sched
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [WIDTH-1:0]           rsp_quo,
  output logic [WIDTH-1:0]           rsp_rem,
  output logic                       rsp_dz,
  output logic                       busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           r_state, w_next;
  logic             r_last;
  logic             r_id, r_dz;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo, r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_grant;
  logic             w_accept, w_gid;
  logic [WIDTH-1:0] w_dvd_sel, w_dsr_sel;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // Ties go to the requester that did not win last time.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == IDLE) begin
      case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;
  assign w_gid     = w_grant[1];
  assign w_dvd_sel = w_gid ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
  assign w_dsr_sel = w_gid ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_dsr_sel == '0) ? DONE : CALC;
      CALC:    if (r_cnt == LAST_STEP) w_next = DONE;
      DONE:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_dz   <= 1'b0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id   <= w_gid;
            r_last <= w_gid;
            r_div  <= w_dsr_sel;
            r_cnt  <= '0;
            // A zero divisor skips CALC; remainder carries the dividend through.
            if (w_dsr_sel == '0) begin
              r_quo <= DZ_QUO[WIDTH-1:0];
              r_rem <= {1'b0, w_dvd_sel};
              r_dz  <= 1'b1;
            end else begin
              r_quo <= w_dvd_sel;
              r_rem <= '0;
              r_dz  <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_id;
  assign rsp_dz    = r_dz;
  assign rsp_quo   = r_quo;
  assign rsp_rem   = r_rem[WIDTH-1:0];

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched against an arithmetic reference model.
module tb_div_sched;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready;
  logic [2*W-1:0] req_dividend, req_divisor;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_dz, busy;
  logic [W-1:0]   rsp_quo, rsp_rem;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int m_last = 1;

  int           g_gid, g_eg, g_lat;
  logic [W-1:0] g_a, g_b, g_q, g_r;
  logic         g_dz, g_id;
  bit           g_ok;
  logic [2*W:0] e;

  always #5 clk = ~clk;

  div_sched #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_quo      (rsp_quo),
    .rsp_rem      (rsp_rem),
    .rsp_dz       (rsp_dz),
    .busy         (busy)
  );

  // Reference: {dz, quotient, remainder} from plain integer division.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, W'(ai / bi), W'(ai % bi)};
  endfunction

  function automatic int ref_grant(input logic [1:0] v);
    if (v == 2'b11) return (m_last == 1) ? 0 : 1;
    return v[1] ? 1 : 0;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
    return (b == '0) ? 1 : W + 1;
  endfunction

  task automatic run_op(input logic [1:0] add, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1);
    int n;
    g_ok = 1'b1;
    @(negedge clk);
    if (add[0]) begin req_dividend[W-1:0] = a0; req_divisor[W-1:0] = b0; end
    if (add[1]) begin req_dividend[2*W-1:W] = a1; req_divisor[2*W-1:W] = b1; end
    req_valid = req_valid | add;
    #1;
    n = 0;
    while ((req_valid & req_ready) == 2'b00 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if ((req_valid & req_ready) == 2'b00) begin g_ok = 1'b0; return; end
    g_eg   = ref_grant(req_valid);
    m_last = g_eg;
    g_gid  = req_ready[1] ? 1 : 0;
    g_a    = req_dividend[W*g_gid +: W];
    g_b    = req_divisor[W*g_gid +: W];
    @(posedge clk); #1;
    req_valid[g_gid] = 1'b0;
    g_lat = 1;
    while (!rsp_valid && g_lat < 60) begin
      @(posedge clk); #1; g_lat++;
    end
    if (!rsp_valid) g_ok = 1'b0;
    g_q  = rsp_quo;
    g_r  = rsp_rem;
    g_dz = rsp_dz;
    g_id = rsp_id;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_dz, busy, rsp_quo, rsp_rem, req_ready} !== '0)
      $display("FAIL reset_outputs: got v=%b id=%b dz=%b busy=%b q=%h r=%h rdy=%b want all 0",
               rsp_valid, rsp_id, rsp_dz, busy, rsp_quo, rsp_rem, req_ready);
    else pass_cnt++;
    rst = 1'b0;
    m_last = 1;
  endtask

  task automatic test_arb();
    run_op(2'b11, 8'd20, 8'd3, 8'd9, 8'd4);
    e = ref_div(g_a, g_b);
    chk_cnt++;
    if ({g_ok, g_id, g_dz, g_q, g_r} !== {1'b1, 1'(g_eg), e} || g_eg != 0)
      $display("FAIL arb_first: got ok=%b id=%b q=%0d r=%0d want id=0 q=%0d r=%0d", g_ok, g_id, g_q, g_r,
               e[2*W-1:W], e[W-1:0]);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 2'b00)
      $display("FAIL arb_ready_in_done: got req_ready=%b want 00", req_ready);
    else pass_cnt++;
    drain();
    run_op(2'b00, '0, '0, '0, '0);
    e = ref_div(g_a, g_b);
    chk_cnt++;
    if ({g_ok, g_id, g_dz, g_q, g_r} !== {1'b1, 1'(g_eg), e} || g_eg != 1)
      $display("FAIL arb_second: got ok=%b id=%b q=%0d r=%0d want id=1 q=%0d r=%0d", g_ok, g_id, g_q, g_r,
               e[2*W-1:W], e[W-1:0]);
    else pass_cnt++;
    drain();
    run_op(2'b11, 8'd20, 8'd3, 8'd9, 8'd4);
    chk_cnt++;
    if ({g_ok, g_id} !== {1'b1, 1'(g_eg)} || g_eg != 0)
      $display("FAIL arb_repeat: got ok=%b id=%b want id=0", g_ok, g_id);
    else pass_cnt++;
    drain();
    run_op(2'b00, '0, '0, '0, '0);
    drain();
  endtask

  task automatic test_single(input string nm, input logic [1:0] port, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    run_op(port, a, b, a, b);
    e = ref_div(a, b);
    chk_cnt++;
    if ({g_ok, g_id, g_dz, g_q, g_r} !== {1'b1, 1'(g_eg), e})
      $display("FAIL %s_result: got ok=%b id=%b dz=%b q=%0d r=%0d want id=%0d dz=%b q=%0d r=%0d", nm,
               g_ok, g_id, g_dz, g_q, g_r, g_eg, e[2*W], e[2*W-1:W], e[W-1:0]);
    else pass_cnt++;
    chk_cnt++;
    if (g_lat != ref_lat(b))
      $display("FAIL %s_latency: got %0d cycles want %0d", nm, g_lat, ref_lat(b));
    else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    logic [2*W+1:0] snap;
    rsp_ready = 1'b0;
    run_op(2'b01, 8'd77, 8'd6, 8'd0, 8'd0);
    req_dividend[2*W-1:W] = 8'd50; req_divisor[2*W-1:W] = 8'd9; req_valid[1] = 1'b1;
    snap = {g_id, g_dz, g_q, g_r};
    e = ref_div(g_a, g_b);
    chk_cnt++;
    if ({g_ok, g_dz, g_q, g_r} !== {1'b1, e})
      $display("FAIL bp_result: got q=%0d r=%0d want q=%0d r=%0d", g_q, g_r, e[2*W-1:W], e[W-1:0]);
    else pass_cnt++;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if ({rsp_valid, busy, req_ready, rsp_id, rsp_dz, rsp_quo, rsp_rem} !== {2'b11, 2'b00, snap})
        $display("FAIL bp_hold: cycle %0d got v=%b busy=%b rdy=%b q=%0d r=%0d", i, rsp_valid, busy,
                 req_ready, rsp_quo, rsp_rem);
      else pass_cnt++;
    end
    drain();
    chk_cnt++;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL bp_release: got v=%b busy=%b want 0 0", rsp_valid, busy);
    else pass_cnt++;
    run_op(2'b00, '0, '0, '0, '0);
    e = ref_div(g_a, g_b);
    chk_cnt++;
    if ({g_ok, g_id, g_dz, g_q, g_r} !== {1'b1, 1'(g_eg), e} || g_eg != 1)
      $display("FAIL bp_queued: got id=%b q=%0d r=%0d want id=1 q=%0d r=%0d", g_id, g_q, g_r,
               e[2*W-1:W], e[W-1:0]);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_midop();
    int seen;
    @(negedge clk);
    req_dividend[W-1:0] = 8'd123; req_divisor[W-1:0] = 8'd5; req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_dz, busy, rsp_quo, rsp_rem} !== '0)
      $display("FAIL midop_reset: got v=%b busy=%b q=%h r=%h want 0", rsp_valid, busy, rsp_quo, rsp_rem);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    m_last = 1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk_cnt++;
    if (seen != 0) $display("FAIL midop_no_rsp: got %0d valid cycles want 0", seen);
    else pass_cnt++;
    test_single("after_reset", 2'b01, 8'd17, 8'd5);
  endtask

  task automatic test_random();
    logic [1:0]   mask;
    logic [W-1:0] a0, b0, a1, b1;
    for (int i = 0; i < 40; i++) begin
      mask = 2'($urandom_range(1, 3));
      a0 = W'($urandom); b0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      a1 = W'($urandom); b1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(mask, a0, b0, a1, b1);
      while (1) begin
        e = ref_div(g_a, g_b);
        chk_cnt++;
        if ({g_ok, g_id, g_dz, g_q, g_r} !== {1'b1, 1'(g_eg), e} || g_lat != ref_lat(g_b))
          $display("FAIL rand_%0d: got ok=%b id=%b dz=%b q=%0d r=%0d lat=%0d want id=%0d dz=%b q=%0d r=%0d lat=%0d",
                   i, g_ok, g_id, g_dz, g_q, g_r, g_lat, g_eg, e[2*W], e[2*W-1:W], e[W-1:0], ref_lat(g_b));
        else pass_cnt++;
        drain();
        if (req_valid == 2'b00 || !g_ok) break;
        run_op(2'b00, '0, '0, '0, '0);
      end
      req_valid = 2'b00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arb();
    test_single("basic", 2'b01, 8'd100, 8'd7);
    test_single("wide", 2'b10, 8'd250, 8'd200);
    test_single("wide_eq", 2'b10, 8'd255, 8'd255);
    test_single("dz", 2'b01, 8'd200, 8'd0);
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
